// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter giving one of NUM_REQ writers burst ownership of a FIFO write port.
// Latency: write path is combinational from the registered grant; one IDLE arbitration cycle separates bursts.
// Backpressure: fifo_full stalls the owner (req_ready low, no write) and the grant is held until full drops.
// Optional: define FIFO_WR_ARB_STATS_EN to add stat_clr / stat_cnt per-requester accepted-word counters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_REQ*16-1:0]         stat_cnt
`endif
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [GID_W-1:0] GID_MAX  = GID_W'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           r_state;
  logic [GID_W-1:0] r_grant_id;
  logic [GID_W-1:0] r_last_owner;
  logic [CNT_W-1:0] r_burst_cnt;

  logic             w_any_valid;
  logic [GID_W-1:0] w_rr_sel;
  logic [GID_W-1:0] w_cand;
  logic             w_own_valid;
  logic             w_own_last;
  logic             w_busy;
  logic             w_xfer;
  logic             w_release;

  assign w_any_valid = |req_valid;
  assign w_busy      = (r_state == S_BURST);

  // Round-robin pick starting after the last owner; scanning from the farthest
  // candidate to the nearest lets the nearest valid requester win without a break.
  always_comb begin
    w_rr_sel = r_last_owner;
    w_cand   = r_last_owner;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_cand = GID_W'((int'(r_last_owner) + off) % NUM_REQ);
      if (req_valid[w_cand]) begin
        w_rr_sel = w_cand;
      end
    end
  end

  // Owner's valid/last bits and write data muxed by the registered grant.
  always_comb begin
    w_own_valid  = 1'b0;
    w_own_last   = 1'b0;
    fifo_wr_data = req_data[DATA_WIDTH-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GID_W'(i)) begin
        w_own_valid  = req_valid[i];
        w_own_last   = req_last[i];
        fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_busy && !fifo_full && (r_grant_id == GID_W'(i));
    end
  end

  // A word moves when the owner is valid and the FIFO is not full. The burst ends
  // on a last word, on the final allowed word, or as soon as the owner goes idle;
  // a stalled-but-valid owner keeps its grant.
  assign w_xfer    = w_busy && w_own_valid && !fifo_full;
  assign w_release = w_busy &&
                     (!w_own_valid ||
                      (w_xfer && (w_own_last || (r_burst_cnt == CNT_LAST))));

  assign fifo_wr_en = w_xfer;
  assign grant_id   = r_grant_id;
  assign busy       = w_busy;

  // Two-state arbitration FSM with grant, burst count and round-robin pointer.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_state      <= S_IDLE;
      r_grant_id   <= '0;
      r_burst_cnt  <= '0;
      r_last_owner <= GID_MAX;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_grant_id  <= w_rr_sel;
            r_burst_cnt <= '0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_release) begin
            r_state      <= S_IDLE;
            r_last_owner <= r_grant_id;
          end else if (w_xfer) begin
            // The closing word is never counted, so the count tops out at MAX_BURST-1.
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] r_stat_cnt;

  // Per-requester accepted-word counters; clear beats a same-cycle increment, and
  // counters stick at all-ones.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stat_clr) begin
          r_stat_cnt[i*16 +: 16] <= 16'h0000;
        end else if (w_xfer && (r_grant_id == GID_W'(i)) &&
                     (r_stat_cnt[i*16 +: 16] != 16'hFFFF)) begin
          r_stat_cnt[i*16 +: 16] <= r_stat_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign stat_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Build with FIFO_WR_ARB_STATS_EN defined to include the counter scenario.
module tb_fifo_wr_arbiter;

  logic        wr_clk = 1'b0;
  logic        wr_rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic        stat_clr;
  logic [63:0] stat_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .wr_clk       (wr_clk),
    .wr_rst_n     (wr_rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_cnt     (stat_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic f, input logic [31:0] d);
    @(negedge wr_clk);
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    req_data  = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    wr_rst_n  = 1'b0;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    @(negedge wr_clk);
    wr_rst_n  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    wr_rst_n  = 1'b0;
    req_valid = 4'hF;
    req_last  = 4'h0;
    req_data  = 32'h0;
    fifo_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    #12;
    // Reset state, even with every requester valid.
    chk("rst_busy",   32'(busy),       0);
    chk("rst_wr_en",  32'(fifo_wr_en), 0);
    chk("rst_ready",  32'(req_ready),  0);
    chk("rst_grant",  32'(grant_id),   0);
    @(negedge wr_clk);
    req_valid = 4'h0;
    wr_rst_n  = 1'b1;

    // Single requester 0: three words, last on the third, then a re-grant.
    step(4'b0001, 4'b0000, 1'b0, 32'h0000_00A1);
    chk("t1_idle_wr_en", 32'(fifo_wr_en), 0);
    chk("t1_idle_busy",  32'(busy),       0);
    step(4'b0001, 4'b0000, 1'b0, 32'h0000_00A1);
    chk("t1_grant", 32'(grant_id),     0);
    chk("t1_busy",  32'(busy),         1);
    chk("t1_ready", 32'(req_ready),    32'b0001);
    chk("t1_w1_en", 32'(fifo_wr_en),   1);
    chk("t1_w1_d",  32'(fifo_wr_data), 32'hA1);
    step(4'b0001, 4'b0000, 1'b0, 32'h0000_00A2);
    chk("t1_w2_en", 32'(fifo_wr_en),   1);
    chk("t1_w2_d",  32'(fifo_wr_data), 32'hA2);
    step(4'b0001, 4'b0001, 1'b0, 32'h0000_00A3);
    chk("t1_w3_en", 32'(fifo_wr_en),   1);
    chk("t1_w3_d",  32'(fifo_wr_data), 32'hA3);
    step(4'b0001, 4'b0000, 1'b0, 32'h0000_00A4);
    chk("t1_gap_busy",  32'(busy),       0);
    chk("t1_gap_wr_en", 32'(fifo_wr_en), 0);
    step(4'b0001, 4'b0001, 1'b0, 32'h0000_00A4);
    chk("t1_regrant_grant", 32'(grant_id),     0);
    chk("t1_regrant_en",    32'(fifo_wr_en),   1);
    chk("t1_regrant_d",     32'(fifo_wr_data), 32'hA4);
    step(4'b0000, 4'b0000, 1'b0, 32'h0);
    chk("t1_end_busy", 32'(busy), 0);

    // All four valid, no last: grants 0,1,2,3,0 with four writes each and a gap.
    do_reset();
    for (int b = 0; b < 5; b++) begin
      g = b % 4;
      step(4'hF, 4'h0, 1'b0, 32'hC3C2_C1C0);
      chk($sformatf("t2_gap%0d_busy", b), 32'(busy),       0);
      chk($sformatf("t2_gap%0d_en",   b), 32'(fifo_wr_en), 0);
      for (int w = 0; w < 4; w++) begin
        step(4'hF, 4'h0, 1'b0, 32'hC3C2_C1C0);
        chk($sformatf("t2_b%0d_w%0d_grant", b, w), 32'(grant_id),     32'(g));
        chk($sformatf("t2_b%0d_w%0d_en",    b, w), 32'(fifo_wr_en),   1);
        chk($sformatf("t2_b%0d_w%0d_d",     b, w), 32'(fifo_wr_data), 32'hC0 + 32'(g));
      end
    end

    // Requester 2 stalled by fifo_full for five cycles after its first word.
    step(4'b0100, 4'b0000, 1'b0, 32'h00B1_0000);
    chk("t3_idle_en", 32'(fifo_wr_en), 0);
    step(4'b0100, 4'b0000, 1'b0, 32'h00B1_0000);
    chk("t3_grant", 32'(grant_id),     2);
    chk("t3_ready", 32'(req_ready),    32'b0100);
    chk("t3_w1_en", 32'(fifo_wr_en),   1);
    chk("t3_w1_d",  32'(fifo_wr_data), 32'hB1);
    for (int k = 0; k < 5; k++) begin
      step(4'b0100, 4'b0000, 1'b1, 32'h00B2_0000);
      chk($sformatf("t3_full%0d_en",    k), 32'(fifo_wr_en), 0);
      chk($sformatf("t3_full%0d_ready", k), 32'(req_ready),  0);
      chk($sformatf("t3_full%0d_grant", k), 32'(grant_id),   2);
      chk($sformatf("t3_full%0d_busy",  k), 32'(busy),       1);
    end
    for (int k = 2; k <= 4; k++) begin
      step(4'b0100, (k == 4) ? 4'b0100 : 4'b0000, 1'b0, 32'(32'hB0 + k) << 16);
      chk($sformatf("t3_w%0d_en", k), 32'(fifo_wr_en),   1);
      chk($sformatf("t3_w%0d_d",  k), 32'(fifo_wr_data), 32'hB0 + 32'(k));
    end
    step(4'b0000, 4'b0000, 1'b0, 32'h0);
    chk("t3_end_busy", 32'(busy), 0);

    // Requester 1 drops valid after two words; requester 3 is next in line.
    step(4'b0010, 4'b0000, 1'b0, 32'h0000_E100);
    chk("t4_idle_en", 32'(fifo_wr_en), 0);
    step(4'b0010, 4'b0000, 1'b0, 32'h0000_E100);
    chk("t4_grant", 32'(grant_id),     1);
    chk("t4_w1_d",  32'(fifo_wr_data), 32'hE1);
    step(4'b0010, 4'b0000, 1'b0, 32'h0000_E200);
    chk("t4_w2_en", 32'(fifo_wr_en),   1);
    chk("t4_w2_d",  32'(fifo_wr_data), 32'hE2);
    step(4'b0000, 4'b0000, 1'b0, 32'h0);
    chk("t4_drop_en",   32'(fifo_wr_en), 0);
    chk("t4_drop_busy", 32'(busy),       1);
    step(4'b1001, 4'b0000, 1'b0, 32'hD100_0000);
    chk("t4_gap_busy", 32'(busy), 0);
    step(4'b1001, 4'b0000, 1'b0, 32'hD100_0000);
    chk("t4_next_grant", 32'(grant_id),     3);
    chk("t4_next_en",    32'(fifo_wr_en),   1);
    chk("t4_next_d",     32'(fifo_wr_data), 32'hD1);

    // Reset pulsed mid-burst of requester 3 takes effect without a clock edge.
    step(4'b1001, 4'b0000, 1'b0, 32'hD200_0000);
    chk("t5_pre_en", 32'(fifo_wr_en), 1);
    wr_rst_n = 1'b0;
    #1;
    chk("t5_rst_en",    32'(fifo_wr_en), 0);
    chk("t5_rst_busy",  32'(busy),       0);
    chk("t5_rst_ready", 32'(req_ready),  0);
    chk("t5_rst_grant", 32'(grant_id),   0);
    @(negedge wr_clk);
    req_valid = 4'hF;
    req_data  = 32'hC3C2_C1C0;
    wr_rst_n  = 1'b1;
    #1;
    chk("t5_rel_en", 32'(fifo_wr_en), 0);
    step(4'hF, 4'h0, 1'b0, 32'hC3C2_C1C0);
    chk("t5_first_grant", 32'(grant_id),   0);
    chk("t5_first_en",    32'(fifo_wr_en), 1);

`ifdef FIFO_WR_ARB_STATS_EN
    // Counters: ten words from requester 0, clear, then saturation.
    do_reset();
    for (int s = 0; s < 13; s++) begin
      step(4'b0001, (s == 12) ? 4'b0001 : 4'b0000, 1'b0, 32'h0);
    end
    step(4'b0000, 4'b0000, 1'b0, 32'h0);
    chk("s_cnt10",    32'(stat_cnt[15:0]),  10);
    chk("s_others",   32'(stat_cnt[63:16] != 48'h0), 0);
    @(negedge wr_clk);
    stat_clr = 1'b1;
    @(negedge wr_clk);
    stat_clr = 1'b0;
    #1;
    chk("s_cleared", 32'(stat_cnt[15:0]), 0);
    force dut.r_stat_cnt = 64'h0000_0000_0000_FFFF;
    @(negedge wr_clk);
    release dut.r_stat_cnt;
    step(4'b0001, 4'b0001, 1'b0, 32'h0);
    step(4'b0001, 4'b0001, 1'b0, 32'h0);
    chk("s_sat_en", 32'(fifo_wr_en), 1);
    step(4'b0000, 4'b0000, 1'b0, 32'h0);
    chk("s_sat", 32'(stat_cnt[15:0]), 32'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
